// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and named register indices for the LEGv8 register file.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] X0  = 5'd0;
  localparam logic [ADDR_W-1:0] X9  = 5'd9;
  localparam logic [ADDR_W-1:0] X30 = 5'd30;
  localparam logic [ADDR_W-1:0] XZR = 5'd31;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear engine: walks every index once, one per cycle, then parks in READY.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clearActive,
  output logic [ADDR_W-1:0] clearAddr,
  output logic              initBusy
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter holds at LAST once READY is reached rather than wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      if (cnt == LAST) begin
        state_nxt = READY;
      end else begin
        cnt_nxt = cnt + ADDR_W'(1);
      end
    end
  end

  assign clearActive = (state == CLEAR);
  assign clearAddr   = cnt;
  assign initBusy    = (state == CLEAR);

endmodule

// File: rtl/register_file_64.sv
// 32 x 64 LEGv8 register file: two combinational read ports, one write port, XZR masking,
// optional same-cycle write-to-read forwarding, and a sequential clear after reset.
module register_file_64
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              regWrite,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              initBusy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clearActive;
  logic [ADDR_W-1:0] clearAddr;
  logic              wr_en;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk         (clk),
    .reset       (reset),
    .clearActive (clearActive),
    .clearAddr   (clearAddr),
    .initBusy    (initBusy)
  );

  assign wr_en = !clearActive && !reset && regWrite && (writeReg != ZERO_IDX);

  // The XZR slot is never written; reads of it are masked below instead.
  always_ff @(posedge clk) begin
    if (clearActive) begin
      if (clearAddr != ZERO_IDX) begin
        mem[clearAddr] <= '0;
      end
    end else if (wr_en) begin
      mem[writeReg] <= writeData;
    end
  end

  always_comb begin
    readData1 = '0;
    if (!clearActive && (readReg1 != ZERO_IDX)) begin
      if ((BYPASS != 0) && wr_en && (writeReg == readReg1)) begin
        readData1 = writeData;
      end else begin
        readData1 = mem[readReg1];
      end
    end
  end

  always_comb begin
    readData2 = '0;
    if (!clearActive && (readReg2 != ZERO_IDX)) begin
      if ((BYPASS != 0) && wr_en && (writeReg == readReg2)) begin
        readData2 = writeData;
      end else begin
        readData2 = mem[readReg2];
      end
    end
  end

endmodule

// File: tb/tb_register_file_64.sv
// Directed and randomized checks of register_file_64, with bypass on (dut_b) and off (dut_n).
module tb_register_file_64;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy_b, busy_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_file_64 #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .readReg1(read_reg1), .readReg2(read_reg2),
    .writeReg(write_reg), .writeData(write_data), .regWrite(reg_write),
    .readData1(rd1_b), .readData2(rd2_b), .initBusy(busy_b)
  );

  register_file_64 #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .readReg1(read_reg1), .readReg2(read_reg2),
    .writeReg(write_reg), .writeData(write_data), .regWrite(reg_write),
    .readData1(rd1_n), .readData2(rd2_n), .initBusy(busy_n)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; reg_write = 1'b0; write_reg = 5'd0; write_data = '0;
    read_reg1 = X9; read_reg2 = X30;
    tick(); tick();
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL reset_busy_b: got %b expected 1", busy_b); end
    checks++; if (busy_n !== 1'b1) begin errors++; $display("FAIL reset_busy_n: got %b expected 1", busy_n); end
    checks++; if (rd1_b !== 64'h0) begin errors++; $display("FAIL reset_rd1: got %h expected 0", rd1_b); end
    checks++; if (rd2_b !== 64'h0) begin errors++; $display("FAIL reset_rd2: got %h expected 0", rd2_b); end
    reset = 1'b0;
    reg_write = 1'b1; write_reg = 5'd5; write_data = 64'hDEAD; read_reg1 = 5'd5; read_reg2 = 5'd5;
    n = 0;
    while (busy_b === 1'b1 && n < 40) begin
      if (n == 16) begin
        checks++; if (rd1_b !== 64'h0) begin errors++; $display("FAIL clear_rd1_mid: got %h expected 0", rd1_b); end
      end
      tick();
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL clear_busy_len: got %0d expected 32", n); end
    reg_write = 1'b0;
    #1;
    checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL clear_busy_n_done: got %b expected 0", busy_n); end
    checks++; if (rd1_b !== 64'h0) begin errors++; $display("FAIL x5_ignored_b: got %h expected 0", rd1_b); end
    checks++; if (rd2_n !== 64'h0) begin errors++; $display("FAIL x5_ignored_n: got %h expected 0", rd2_n); end
  endtask

  task automatic test_write_read();
    reg_write = 1'b1; write_reg = X9; write_data = 64'h0123_4567_89AB_CDEF;
    read_reg1 = X0; read_reg2 = X0;
    tick();
    reg_write = 1'b0; read_reg1 = X9; read_reg2 = X9;
    #1;
    checks++; if (rd1_b !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL wr_x9_rd1: got %h expected 0123456789abcdef", rd1_b); end
    checks++; if (rd2_b !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL wr_x9_rd2: got %h expected 0123456789abcdef", rd2_b); end
    checks++; if (rd1_n !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL wr_x9_rd1_n: got %h expected 0123456789abcdef", rd1_n); end
  endtask

  task automatic test_xzr();
    reg_write = 1'b1; write_reg = XZR; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    read_reg1 = XZR; read_reg2 = XZR;
    #1;
    checks++; if (rd1_b !== 64'h0) begin errors++; $display("FAIL xzr_same_rd1: got %h expected 0", rd1_b); end
    checks++; if (rd2_b !== 64'h0) begin errors++; $display("FAIL xzr_same_rd2: got %h expected 0", rd2_b); end
    tick();
    reg_write = 1'b0;
    #1;
    checks++; if (rd1_b !== 64'h0) begin errors++; $display("FAIL xzr_next_rd1: got %h expected 0", rd1_b); end
    checks++; if (rd2_n !== 64'h0) begin errors++; $display("FAIL xzr_next_rd2_n: got %h expected 0", rd2_n); end
    tick();
    checks++; if (rd2_b !== 64'h0) begin errors++; $display("FAIL xzr_later_rd2: got %h expected 0", rd2_b); end
  endtask

  task automatic test_bypass();
    reg_write = 1'b1; write_reg = 5'd3; write_data = 64'h42;
    read_reg1 = 5'd3; read_reg2 = 5'd3;
    #1;
    checks++; if (rd1_b !== 64'h42) begin errors++; $display("FAIL bypass_rd1: got %h expected 42", rd1_b); end
    checks++; if (rd2_b !== 64'h42) begin errors++; $display("FAIL bypass_rd2: got %h expected 42", rd2_b); end
    checks++; if (rd1_n !== 64'h0) begin errors++; $display("FAIL nobypass_old: got %h expected 0", rd1_n); end
    tick();
    reg_write = 1'b0;
    #1;
    checks++; if (rd1_n !== 64'h42) begin errors++; $display("FAIL nobypass_new: got %h expected 42", rd1_n); end
    checks++; if (rd2_b !== 64'h42) begin errors++; $display("FAIL bypass_kept: got %h expected 42", rd2_b); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int i = 0; i < 31; i++) begin
      reg_write = 1'b1; write_reg = 5'(i); write_data = 64'(i) * 64'h1111;
      tick();
    end
    reg_write = 1'b0; read_reg1 = X30; read_reg2 = X9;
    #1;
    checks++; if (rd1_b !== 64'h1FFFE) begin errors++; $display("FAIL load_x30: got %h expected 1fffe", rd1_b); end
    checks++; if (rd2_b !== 64'h9999) begin errors++; $display("FAIL load_x9: got %h expected 9999", rd2_b); end
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (10) tick();
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b expected 1", busy_b); end
    reset = 1'b1; tick(); reset = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL restart_busy_len: got %0d expected 32", n); end
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      #1;
      checks++; if (rd1_b !== 64'h0) begin errors++; $display("FAIL restart_zero_rd1[%0d]: got %h expected 0", i, rd1_b); end
      checks++; if (rd2_n !== 64'h0) begin errors++; $display("FAIL restart_zero_rd2_n[%0d]: got %h expected 0", 31 - i, rd2_n); end
    end
  endtask

  task automatic test_random();
    logic [63:0] mdl [32];
    logic [63:0] e1b, e2b, e1n, e2n;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int c = 0; c < 10000; c++) begin
      reg_write  = 1'($urandom_range(0, 1));
      write_reg  = 5'($urandom_range(0, 31));
      write_data = {$urandom, $urandom};
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      #1;
      e1n = (read_reg1 == XZR) ? 64'h0 : mdl[read_reg1];
      e2n = (read_reg2 == XZR) ? 64'h0 : mdl[read_reg2];
      e1b = (reg_write && write_reg != XZR && write_reg == read_reg1) ? write_data : e1n;
      e2b = (reg_write && write_reg != XZR && write_reg == read_reg2) ? write_data : e2n;
      checks++; if (rd1_b !== e1b) begin errors++; $display("FAIL rand_rd1_b c=%0d r=%0d: got %h expected %h", c, read_reg1, rd1_b, e1b); end
      checks++; if (rd2_b !== e2b) begin errors++; $display("FAIL rand_rd2_b c=%0d r=%0d: got %h expected %h", c, read_reg2, rd2_b, e2b); end
      checks++; if (rd1_n !== e1n) begin errors++; $display("FAIL rand_rd1_n c=%0d r=%0d: got %h expected %h", c, read_reg1, rd1_n, e1n); end
      checks++; if (rd2_n !== e2n) begin errors++; $display("FAIL rand_rd2_n c=%0d r=%0d: got %h expected %h", c, read_reg2, rd2_n, e2n); end
      tick();
      if (reg_write && write_reg != XZR) mdl[write_reg] = write_data;
    end
    reg_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_xzr();
    test_bypass();
    test_reset_mid_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
